// File: rtl/mul_sequencer.sv
// mul_sequencer: multi-cycle shift-add multiply sequencer for the ARM core.
// It accepts a multiply command, holds the core in stall while the product is
// built, and then writes the result back through the single register write
// port. Short forms write RdLo only. Long forms write RdLo and then RdHi.
// Ports:
//   clk, reset (async, active low)
//   start, mul_ctl{mult,op[2:0]}, set_flags, op_a (Rm), op_b (Rs),
//   acc_lo, acc_hi                      -- command inputs, sampled on accept
//   stall, busy                         -- core hold / engine occupied
//   wr_en, wr_sel, wr_data              -- register writeback (0=RdLo, 1=RdHi)
//   flag_we, flag_n, flag_z             -- N/Z update on the final write
//   done                                -- pulse in the final writeback cycle
module mul_sequencer #(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  mul_ctl,
  input  logic        set_flags,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic [31:0] acc_lo,
  input  logic [31:0] acc_hi,
  output logic        stall,
  output logic        busy,
  output logic        wr_en,
  output logic        wr_sel,
  output logic [31:0] wr_data,
  output logic        flag_we,
  output logic        flag_n,
  output logic        flag_z,
  output logic        done
);
  localparam int N_ITER = 32 / BITS_PER_CYCLE;

  typedef enum logic [2:0] {S_IDLE, S_CALC, S_FIX, S_WB_LO, S_WB_HI} state_t;

  state_t      state;
  logic [5:0]  cnt;
  logic [63:0] mcand;    // multiplicand, shifted left as multiplier bits retire
  logic [31:0] mplier;   // multiplier, shifted right; low bits are the next digit
  logic [63:0] prod;
  logic [63:0] acc;
  logic        neg, is_long, add_acc, sf;

  logic        accept;
  logic [2:0]  op;
  logic        sgn;
  logic [31:0] mag_a, mag_b;
  logic [63:0] pp, fixed;

  assign op     = mul_ctl[2:0];
  assign accept = (state == S_IDLE) && start && mul_ctl[3];
  assign sgn    = op[2] & op[1];
  // Magnitude of 0x80000000 wraps back to 0x80000000, which is the correct
  // unsigned magnitude, so 32 bits suffice.
  assign mag_a  = (sgn && op_a[31]) ? (~op_a + 32'd1) : op_a;
  assign mag_b  = (sgn && op_b[31]) ? (~op_b + 32'd1) : op_b;

  // Partial product for the current multiplier digit.
  always_comb begin
    pp = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++)
      if (mplier[i]) pp = pp + (mcand << i);
  end

  assign fixed = (neg ? (~prod + 64'd1) : prod) + (add_acc ? acc : 64'd0);

  assign busy  = (state != S_IDLE);
  // done marks the final writeback, so the core is released in that cycle.
  assign stall = accept | (busy & ~done);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      prod    <= '0;
      acc     <= '0;
      neg     <= 1'b0;
      is_long <= 1'b0;
      add_acc <= 1'b0;
      sf      <= 1'b0;
      wr_en   <= 1'b0;
      wr_sel  <= 1'b0;
      wr_data <= '0;
      flag_we <= 1'b0;
      flag_n  <= 1'b0;
      flag_z  <= 1'b0;
      done    <= 1'b0;
    end else begin
      wr_en   <= 1'b0;
      flag_we <= 1'b0;
      done    <= 1'b0;
      case (state)
        S_IDLE: if (accept) begin
          mcand   <= {32'd0, mag_a};
          mplier  <= mag_b;
          neg     <= sgn & (op_a[31] ^ op_b[31]);
          is_long <= op[2];
          add_acc <= op[0];
          acc     <= op[2] ? {acc_hi, acc_lo} : {32'd0, acc_lo};
          sf      <= set_flags;
          prod    <= '0;
          cnt     <= '0;
          state   <= S_CALC;
        end
        S_CALC: begin
          prod   <= prod + pp;
          mcand  <= mcand << BITS_PER_CYCLE;
          mplier <= mplier >> BITS_PER_CYCLE;
          cnt    <= cnt + 6'd1;
          if (cnt == 6'(N_ITER - 1)) state <= S_FIX;
        end
        S_FIX: begin
          prod    <= fixed;
          wr_en   <= 1'b1;
          wr_sel  <= 1'b0;
          wr_data <= fixed[31:0];
          flag_n  <= is_long ? fixed[63] : fixed[31];
          flag_z  <= is_long ? (fixed == 64'd0) : (fixed[31:0] == 32'd0);
          if (!is_long) begin
            done    <= 1'b1;
            flag_we <= sf;
          end
          state <= S_WB_LO;
        end
        S_WB_LO: begin
          if (is_long) begin
            wr_en   <= 1'b1;
            wr_sel  <= 1'b1;
            wr_data <= prod[63:32];
            done    <= 1'b1;
            flag_we <= sf;
            state   <= S_WB_HI;
          end else begin
            state <= S_IDLE;
          end
        end
        S_WB_HI: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
